valor_inmediato_seg: RTL and testbench
======================================

VALOR_INMEDIATO_SEG -- requirements
Module: valor_inmediato_seg

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate data width; legal values 32 and 64.
REQ-002 SHALL have parameter PROF, default 2, buffer depth in entries; legal values 2 to 8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream request qualifier.
REQ-006 SHALL have port in_ready, output, 1, block can accept an entry.
REQ-007 SHALL have port inst, input, 32, full instruction word.
REQ-008 SHALL have port tipo, input, 3, immediate format selector.
REQ-009 SHALL have port out_valid, output, 1, an immediate is presented.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the presented immediate.
REQ-011 SHALL have port inmediato, output, XLEN, generated immediate.
REQ-012 SHALL have port ilegal, output, 1, presented entry had an unsupported tipo.

Function
REQ-013 SHALL transfer in on a cycle with in_valid=1 and in_ready=1; out on out_valid=1 and out_ready=1.
REQ-014 SHALL form the immediate at push time and store {inmediato, ilegal} in a PROF-entry FIFO; FIFO order is preserved.
REQ-015 SHALL give latency 1: an entry pushed into an empty FIFO is presented in the next cycle.
REQ-016 SHALL drive in_ready = (count < PROF) and out_valid = (count != 0), where count is the stored occupancy.
REQ-017 SHALL, on a simultaneous push and pop, keep count unchanged; push into a full FIFO cannot occur because in_ready=0.
REQ-018 SHALL wrap read and write pointers modulo PROF.
REQ-019 SHALL hold inmediato and ilegal stable while out_valid=1 and out_ready=0.
REQ-020 SHALL decode tipo 000 as I: sign-extended inst[31:20].
REQ-021 SHALL decode tipo 001 as S: sign-extended {inst[31:25], inst[11:7]}.
REQ-022 SHALL decode tipo 010 as B: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
REQ-023 SHALL decode tipo 011 as U: {inst[31:12], 12 zeros}, sign-extended to XLEN.
REQ-024 SHALL decode tipo 100 as J: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
REQ-025 SHALL decode tipo 101 as Z (CSR zimm): inst[19:15] zero-extended.
REQ-026 SHALL decode tipo 110 as shift amount: inst[24:20] zero-extended when XLEN=32, and inst[25:20] when XLEN=64.
REQ-027 SHALL decode tipo 111 as illegal: immediate all zeros, ilegal=1; all other tipo values give ilegal=0.
REQ-028 SHALL drive inmediato to zero when out_valid=0.

Reset
REQ-029 SHALL, while rst_n=0, force count=0, both pointers to 0, out_valid=0, in_ready=0, inmediato=0, ilegal=0.
REQ-030 SHALL raise in_ready on the first rising clk edge after rst_n deasserts.
REQ-031 SHALL discard all buffered entries when reset is asserted mid-operation; no entry is presented after reset.

Configuration
REQ-032 SHALL, when macro VALOR_INMEDIATO_CNT_ILEGAL_EN is defined, add output cnt_ilegal (8 bits, reset 0) that increments on every pushed entry with tipo=111 and saturates at 255.
REQ-033 SHALL, without VALOR_INMEDIATO_CNT_ILEGAL_EN, omit the cnt_ilegal port and counter; all other behaviour is identical.

Verification
REQ-034 SHALL verify decoding: XLEN=32, push inst=0xFFF00093 with tipo=000 -> inmediato=0xFFFFFFFF one cycle later, ilegal=0.
REQ-035 SHALL verify B-type and XLEN: XLEN=64, push inst=0x80000063 with tipo=010 -> inmediato=0xFFFFFFFFFFFFF000.
REQ-036 SHALL verify backpressure: PROF=2, out_ready=0, push 3 entries -> in_ready=0 after the 2nd entry; raise out_ready -> entries come out in order and in_ready=1 after the first pop.
REQ-037 SHALL verify simultaneous push and pop: count=1, push and pop in one cycle -> count remains 1 and the next entry is presented.
REQ-038 SHALL verify illegal type: push tipo=111 -> inmediato=0, ilegal=1; with VALOR_INMEDIATO_CNT_ILEGAL_EN, 300 such pushes -> cnt_ilegal=255.
REQ-039 SHALL verify reset mid-operation: 2 entries buffered, pulse rst_n low -> out_valid=0 immediately, and nothing is presented afterwards without a new push.

Source files
------------

// File: rtl/valor_inmediato_seg.sv
// Immediate generator: decodes the immediate from inst/tipo and queues it.
// Latency 1: an entry pushed into an empty buffer is presented the next cycle.
// Backpressure: valid/ready on both sides; in_ready drops when PROF entries are held.
//
// Parameters:
//   XLEN   immediate width, 32 or 64
//   PROF   buffer depth in entries, 2..8
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake carrying inst and tipo
//   inst[31:0]          full instruction word
//   tipo[2:0]           immediate format: I,S,B,U,J,Z,shamt,illegal (000..111)
//   out_valid/out_ready downstream handshake carrying inmediato and ilegal
//   inmediato[XLEN-1:0] generated immediate, zero when out_valid=0
//   ilegal              presented entry had tipo=111
//   cnt_ilegal[7:0]     saturating count of pushed tipo=111 entries
//                       (present only with VALOR_INMEDIATO_CNT_ILEGAL_EN defined)

module valor_inmediato_seg #(
  parameter int XLEN = 32,
  parameter int PROF = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [2:0]      tipo,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] inmediato,
  output logic            ilegal
`ifdef VALOR_INMEDIATO_CNT_ILEGAL_EN
  ,
  output logic [7:0]      cnt_ilegal
`endif
);

  localparam int PW = (PROF > 1) ? $clog2(PROF) : 1;
  localparam int CW = $clog2(PROF + 1);

  localparam logic [CW-1:0] PROF_C = CW'(PROF);
  localparam logic [PW-1:0] ULT_C  = PW'(PROF - 1);

  // ---------------------------------------------------------------------------
  // Decode (combinational, evaluated on the incoming word at push time)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_d;
  logic            ilegal_d;
  logic [11:0]     imm_s;
  logic [12:0]     imm_b;
  logic [20:0]     imm_j;
  logic [31:0]     imm_u;

  assign imm_s = {inst[31:25], inst[11:7]};
  assign imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};

  always_comb begin
    imm_d    = '0;
    ilegal_d = 1'b0;
    unique case (tipo)
      3'b000: imm_d = XLEN'($signed(inst[31:20]));
      3'b001: imm_d = XLEN'($signed(imm_s));
      3'b010: imm_d = XLEN'($signed(imm_b));
      3'b011: imm_d = XLEN'($signed(imm_u));
      3'b100: imm_d = XLEN'($signed(imm_j));
      3'b101: imm_d = XLEN'(inst[19:15]);
      3'b110: begin
        // RV64 shifts take a 6-bit amount, RV32 only 5 bits.
        if (XLEN == 64) imm_d = XLEN'(inst[25:20]);
        else            imm_d = XLEN'(inst[24:20]);
      end
      default: begin
        imm_d    = '0;
        ilegal_d = 1'b1;
      end
    endcase
  end

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          arranque;  // low in reset, set by the first edge afterwards
  logic [XLEN:0] mem [PROF];
  logic [XLEN:0] cabeza;
  logic          push;
  logic          pop;

  assign out_valid = (count != '0);
  assign in_ready  = arranque && (count < PROF_C);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  function automatic logic [PW-1:0] sig_ptr(input logic [PW-1:0] p);
    return (p == ULT_C) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arranque <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      arranque <= 1'b1;
      if (push) wr_ptr <= sig_ptr(wr_ptr);
      if (pop)  rd_ptr <= sig_ptr(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count=0 masks every entry.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ilegal_d, imm_d};
  end

  assign cabeza    = mem[rd_ptr];
  assign inmediato = out_valid ? cabeza[XLEN-1:0] : '0;
  assign ilegal    = out_valid & cabeza[XLEN];

`ifdef VALOR_INMEDIATO_CNT_ILEGAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ilegal <= 8'd0;
    end else if (push && (tipo == 3'b111) && (cnt_ilegal != 8'hFF)) begin
      cnt_ilegal <= cnt_ilegal + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_valor_inmediato_seg.sv
module tb_valor_inmediato_seg;

  localparam int PROF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inst;
  logic [2:0]  tipo;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, ilegal_a;
  logic [31:0] inmediato_a;
  logic        in_ready_b, out_valid_b, ilegal_b;
  logic [63:0] inmediato_b;
`ifdef VALOR_INMEDIATO_CNT_ILEGAL_EN
  logic [7:0]  cnt_a, cnt_b;
  int          cnt_m;
`endif

  always #5 clk = ~clk;

  valor_inmediato_seg #(.XLEN(32), .PROF(PROF)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .inst(inst), .tipo(tipo), .out_valid(out_valid_a), .out_ready(out_ready),
    .inmediato(inmediato_a), .ilegal(ilegal_a)
`ifdef VALOR_INMEDIATO_CNT_ILEGAL_EN
    , .cnt_ilegal(cnt_a)
`endif
  );

  valor_inmediato_seg #(.XLEN(64), .PROF(PROF)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .inst(inst), .tipo(tipo), .out_valid(out_valid_b), .out_ready(out_ready),
    .inmediato(inmediato_b), .ilegal(ilegal_b)
`ifdef VALOR_INMEDIATO_CNT_ILEGAL_EN
    , .cnt_ilegal(cnt_b)
`endif
  );

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic        ilg;
  } exp_t;

  exp_t sbq[$];
  int   vecs = 0;
  int   errs = 0;
  bit   mrdy = 0;

  function automatic logic [63:0] modelo(input logic [31:0] i, input logic [2:0] t, input bit x64);
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [31:0] u32;
    s12 = {i[31:25], i[11:7]};
    b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    u32 = {i[31:12], 12'h000};
    case (t)
      3'd0:    return 64'($signed(i[31:20]));
      3'd1:    return 64'($signed(s12));
      3'd2:    return 64'($signed(b13));
      3'd3:    return 64'($signed(u32));
      3'd4:    return 64'($signed(j21));
      3'd5:    return {59'd0, i[19:15]};
      3'd6:    return x64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs at negedge against the scoreboard, update it with
  // the transfers that the coming rising edge performs, then advance.
  task automatic tick();
    bit    exp_valid, exp_ready;
    exp_t  h;
    logic [63:0] v64;
    exp_t  e;
    @(negedge clk);
    exp_valid = (sbq.size() != 0);
    exp_ready = mrdy && (sbq.size() < PROF);
    chk("a_out_valid", 64'(out_valid_a), 64'(exp_valid));
    chk("b_out_valid", 64'(out_valid_b), 64'(exp_valid));
    chk("a_in_ready",  64'(in_ready_a),  64'(exp_ready));
    chk("b_in_ready",  64'(in_ready_b),  64'(exp_ready));
    if (exp_valid) begin
      h = sbq[0];
      chk("a_inmediato", 64'(inmediato_a), 64'(h.imm32));
      chk("b_inmediato", inmediato_b, h.imm64);
      chk("a_ilegal", 64'(ilegal_a), 64'(h.ilg));
      chk("b_ilegal", 64'(ilegal_b), 64'(h.ilg));
    end else begin
      chk("a_inmediato_idle", 64'(inmediato_a), 64'd0);
      chk("b_inmediato_idle", inmediato_b, 64'd0);
      chk("a_ilegal_idle", 64'(ilegal_a), 64'd0);
    end
`ifdef VALOR_INMEDIATO_CNT_ILEGAL_EN
    chk("a_cnt_ilegal", 64'(cnt_a), 64'(cnt_m));
    chk("b_cnt_ilegal", 64'(cnt_b), 64'(cnt_m));
`endif
    if (rst_n && exp_valid && out_ready) void'(sbq.pop_front());
    if (rst_n && exp_ready && in_valid) begin
      v64     = modelo(inst, tipo, 1'b0);
      e.imm32 = v64[31:0];
      e.imm64 = modelo(inst, tipo, 1'b1);
      e.ilg   = (tipo == 3'b111);
      sbq.push_back(e);
`ifdef VALOR_INMEDIATO_CNT_ILEGAL_EN
      if (tipo == 3'b111 && cnt_m < 255) cnt_m++;
`endif
    end
    @(posedge clk);
    if (rst_n) mrdy = 1;
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] i, input logic [2:0] t);
    in_valid = v;
    inst     = i;
    tipo     = t;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; inst = '0; tipo = '0; out_ready = 1'b0;
`ifdef VALOR_INMEDIATO_CNT_ILEGAL_EN
    cnt_m = 0;
`endif
    #1;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_in_ready",  64'(in_ready_b),  64'd0);
    chk("rst_inmediato", inmediato_b,      64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();            // no edge seen yet after release: in_ready still low
    tick();

    // Sign-extended I immediate, then B immediate on the 64-bit build.
    out_ready = 1'b1;
    drive(1, 32'hFFF0_0093, 3'b000);
    drive(0, 32'h0, 3'b000);
    drive(1, 32'h8000_0063, 3'b010);
    drive(0, 32'h0, 3'b000);

    // Every format with positive and negative words, back to back.
    for (int t = 0; t < 8; t++) begin
      drive(1, 32'hFEDC_BA98 ^ (32'(t) << 9), 3'(t));
      drive(1, $urandom() & 32'h7FFF_FFFF, 3'(t));
      drive(1, 32'h8000_0000 | $urandom(), 3'(t));
    end
    drive(0, 32'h0, 3'b000);
    drive(0, 32'h0, 3'b000);

    // Backpressure: fill, hold, then drain with a simultaneous push/pop.
    out_ready = 1'b0;
    drive(1, 32'h1230_0013, 3'b000);
    drive(1, 32'hABCD_E037, 3'b011);
    drive(1, 32'h0200_0013, 3'b110);
    drive(1, 32'h0200_0013, 3'b110);
    out_ready = 1'b1;
    drive(1, 32'h0200_0013, 3'b110);
    drive(1, 32'h0200_0013, 3'b110);
    drive(1, 32'h0000_0000, 3'b000);   // count stays at one
    drive(0, 32'h0, 3'b000);
    drive(0, 32'h0, 3'b000);

    // Illegal format.
    drive(1, 32'hFFFF_FFFF, 3'b111);
    drive(0, 32'h0, 3'b000);
    drive(0, 32'h0, 3'b000);

`ifdef VALOR_INMEDIATO_CNT_ILEGAL_EN
    for (int k = 0; k < 300; k++) drive(1, $urandom(), 3'b111);
    drive(0, 32'h0, 3'b000);
    drive(0, 32'h0, 3'b000);
    chk("cnt_saturated", 64'(cnt_a), 64'd255);
`endif

    // Reset with two entries buffered.
    out_ready = 1'b0;
    drive(1, 32'h7FF0_0013, 3'b000);
    drive(1, 32'h8000_00EF, 3'b100);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid_a", 64'(out_valid_a), 64'd0);
    chk("midrst_out_valid_b", 64'(out_valid_b), 64'd0);
    chk("midrst_in_ready",    64'(in_ready_a),  64'd0);
    chk("midrst_inmediato",   inmediato_b,      64'd0);
    sbq.delete();
    mrdy = 0;
`ifdef VALOR_INMEDIATO_CNT_ILEGAL_EN
    cnt_m = 0;
`endif
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) drive(0, 32'h0, 3'b000);

    // Still functional after reset.
    drive(1, 32'h0010_0093, 3'b001);
    drive(0, 32'h0, 3'b000);
    drive(0, 32'h0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
